cordic_vectoring: RTL and testbench

Iterative CORDIC vectoring engine: converts a Cartesian vector (x, y) in Q0.N_FRAC into magnitude (carrying the CORDIC gain) and angle (in units of π). It is the counterpart of the rotation-mode path. That path folds an angle into the ±90° region of convergence before rotating. This block instead folds the vector into the right half-plane, then restores the quadrant offset in the accumulated angle. It sits after the wave datapath for phase/amplitude measurement and shares the strobe-based valid protocol of the CORDIC chain.

---
 rtl/cordic_vectoring.sv | 142 ++++++++++++++
 tb/tb_cordic_vectoring.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring engine: (x, y) in Q0.N_FRAC -> gain-scaled magnitude and
// angle in units of pi. The vector is folded into the right half-plane on load.
module cordic_vectoring #(
    parameter int N_FRAC = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [N_FRAC:0]   x_i,
    input  logic signed [N_FRAC:0]   y_i,
    input  logic                     data_in_valid_strobe_i,
    output logic                     ready_o,
    output logic [N_FRAC+2:0]        mag_o,
    output logic signed [N_FRAC:0]   angle_o,
    output logic                     data_out_valid_strobe_o
);

    localparam int XW = N_FRAC + 3;
    localparam int ZW = N_FRAC + 2;
    localparam logic signed [ZW-1:0] HALF       = ZW'(1 << (N_FRAC - 1));
    localparam logic signed [ZW-1:0] MINUS_HALF = -HALF;
    localparam logic signed [ZW-1:0] ANG_MAX    = ZW'((1 << N_FRAC) - 1);
    localparam logic signed [ZW-1:0] ANG_MIN    = -ZW'(1 << N_FRAC);

    typedef enum logic {IDLE, ITER} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]   z_q, z_d;
    logic [XW-1:0]          mag_q, mag_d;
    logic signed [N_FRAC:0] ang_q, ang_d;
    logic                   vld_q, vld_d;

    logic signed [XW-1:0]   xe, ye, x_sh, y_sh, x_it, y_it;
    logic signed [ZW-1:0]   atan_i, z_it;

    function automatic logic signed [ZW-1:0] atan_lut(input logic [2:0] i);
        case (i)
            3'd0:    atan_lut = ZW'(32);
            3'd1:    atan_lut = ZW'(19);
            3'd2:    atan_lut = ZW'(10);
            3'd3:    atan_lut = ZW'(5);
            3'd4:    atan_lut = ZW'(3);
            3'd5:    atan_lut = ZW'(1);
            3'd6:    atan_lut = ZW'(1);
            default: atan_lut = '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        mag_d   = mag_q;
        ang_d   = ang_q;
        vld_d   = 1'b0;

        // Sign-extend before negating so that -128 folds without overflow.
        xe     = {{(XW-N_FRAC-1){x_i[N_FRAC]}}, x_i};
        ye     = {{(XW-N_FRAC-1){y_i[N_FRAC]}}, y_i};
        x_sh   = x_q >>> cnt_q;
        y_sh   = y_q >>> cnt_q;
        atan_i = atan_lut(cnt_q);
        if (y_q[XW-1]) begin
            x_it = x_q - y_sh;
            y_it = y_q + x_sh;
            z_it = z_q - atan_i;
        end else begin
            x_it = x_q + y_sh;
            y_it = y_q - x_sh;
            z_it = z_q + atan_i;
        end

        case (state_q)
            IDLE: begin
                if (data_in_valid_strobe_i) begin
                    if (!x_i[N_FRAC]) begin
                        x_d = xe;
                        y_d = ye;
                        z_d = '0;
                    end else if (!y_i[N_FRAC]) begin
                        x_d = ye;
                        y_d = -xe;
                        z_d = HALF;
                    end else begin
                        x_d = -ye;
                        y_d = xe;
                        z_d = MINUS_HALF;
                    end
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                x_d   = x_it;
                y_d   = y_it;
                z_d   = z_it;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    state_d = IDLE;
                    mag_d   = x_it;
                    vld_d   = 1'b1;
                    if (z_it > ANG_MAX)      ang_d = ANG_MAX[N_FRAC:0];
                    else if (z_it < ANG_MIN) ang_d = ANG_MIN[N_FRAC:0];
                    else                     ang_d = z_it[N_FRAC:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rst_i is active-low despite its name.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mag_q   <= '0;
            ang_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            mag_q   <= mag_d;
            ang_q   <= ang_d;
            vld_q   <= vld_d;
        end
    end

    assign ready_o                 = (state_q == IDLE);
    assign mag_o                   = mag_q;
    assign angle_o                 = ang_q;
    assign data_out_valid_strobe_o = vld_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring; expected magnitudes/angles are hand-iterated.
module tb_cordic_vectoring;

    logic              clk;
    logic              rst_n;
    logic signed [7:0] x, y;
    logic              stb;
    logic              rdy;
    logic [9:0]        mag;
    logic signed [7:0] ang;
    logic              vld;

    int total = 0;
    int bad   = 0;

    cordic_vectoring #(.N_FRAC(7)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst_n),
        .x_i                     (x),
        .y_i                     (y),
        .data_in_valid_strobe_i  (stb),
        .ready_o                 (rdy),
        .mag_o                   (mag),
        .angle_o                 (ang),
        .data_out_valid_strobe_o (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept one vector, wait for the valid pulse, check latency, results and pulse width.
    task automatic run_vec(input string tag, input logic signed [7:0] xv, input logic signed [7:0] yv,
                           input int emag, input int eang);
        int n;
        n = 0;
        @(negedge clk);
        chk({tag, "_ready_before"}, 32'(rdy), 1);
        x = xv; y = yv; stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        chk({tag, "_busy"}, 32'(rdy), 0);
        while (!vld && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 7);
        chk({tag, "_mag"}, 32'(mag), emag);
        chk({tag, "_angle"}, 32'(ang), eang);
        @(posedge clk); #1;
        chk({tag, "_pulse_width"}, 32'(vld), 0);
        chk({tag, "_ready_after"}, 32'(rdy), 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; stb = 1'b0; x = '0; y = '0;
        #2;
        chk("rst_ready", 32'(rdy), 1);
        chk("rst_mag",   32'(mag), 0);
        chk("rst_angle", 32'(ang), 0);
        chk("rst_valid", 32'(vld), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_vec("p64_0",    8'sd64,   8'sd0,   106,    1);
        run_vec("p0_64",    8'sd0,    8'sd64,  107,   63);
        run_vec("p0_m64",   8'sd0,   -8'sd64,  106,  -63);
        run_vec("pm45_m45", -8'sd45, -8'sd45,  108,  -97);
        run_vec("p45_45",   8'sd45,   8'sd45,  108,   31);
        run_vec("pm64_0",  -8'sd64,   8'sd0,   107,  127);
        run_vec("pm128_m1", -8'sd128, -8'sd1,  212, -127);
        run_vec("p127_127", 8'sd127,  8'sd127, 298,   31);

        // Strobe held high: accepts at E0 and E8; inputs wiggle while busy.
        @(negedge clk);
        x = 8'sd64; y = 8'sd0; stb = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            chk($sformatf("cont_valid_e%0d", k), 32'(vld), (k == 7 || k == 15) ? 1 : 0);
            chk($sformatf("cont_ready_e%0d", k), 32'(rdy), (k == 7 || k >= 15) ? 1 : 0);
            if (k == 7) begin
                chk("cont_mag1",   32'(mag), 106);
                chk("cont_angle1", 32'(ang), 1);
            end
            if (k == 15) begin
                chk("cont_mag2",   32'(mag), 108);
                chk("cont_angle2", 32'(ang), 31);
            end
            case (k)
                0:  begin x = 8'sd45;   y = 8'sd45;  end
                3:  begin x = -8'sd128; y = -8'sd1;  end
                5:  begin x = 8'sd45;   y = 8'sd45;  end
                9:  begin stb = 1'b0; x = 8'sd0; y = -8'sd64; end
                12: begin x = 8'sd127;  y = 8'sd127; end
                default: ;
            endcase
        end

        // Strobe at the valid edge is ignored; the one a cycle later is accepted.
        @(negedge clk);
        x = 8'sd0; y = 8'sd64; stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        x = 8'sd127; y = 8'sd127; stb = 1'b1;
        @(posedge clk); #1;
        chk("late_valid_e7", 32'(vld), 1);
        chk("late_mag",      32'(mag), 107);
        chk("late_angle",    32'(ang), 63);
        x = 8'sd0; y = -8'sd64;
        @(posedge clk); #1;
        stb = 1'b0;
        chk("late_accept_e8", 32'(rdy), 0);
        n = 0;
        while (!vld && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("late_latency", n, 7);
        chk("late_mag2",    32'(mag), 106);
        chk("late_angle2",  32'(ang), -63);

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        x = 8'sd127; y = 8'sd127; stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mag",   32'(mag), 0);
        chk("arst_angle", 32'(ang), 0);
        chk("arst_valid", 32'(vld), 0);
        chk("arst_ready", 32'(rdy), 1);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (vld) n++;
        end
        chk("arst_no_pulse", n, 0);
        run_vec("post_rst", -8'sd45, -8'sd45, 108, -97);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
